// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register: ALU control codes,
// ALUOP encodings, forwarding selects and the registered control bundle.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MWB = 2'd1,
    FWD_EXM = 2'd2
  } fwd_sel_e;

  // All-zero value of this struct is the bubble: no side effects, decodes to add.
  typedef struct packed {
    logic   valid;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   branch;
    logic   alusrc;
    aluop_e aluop;
    logic [2:0] funct3;
    logic   funct7b5;
  } ex_ctrl_t;

  function automatic logic [3:0] alu_decode(aluop_e op, logic [2:0] funct3, logic funct7b5);
    logic [3:0] code;
    code = ALU_ADD;
    case (op)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADDSUB: code = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:    code = ALU_AND;
          F3_OR:     code = ALU_OR;
          default:   code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode/forwarding environment (master) and the
// ID/EX stage (slave).
interface id_ex_stage_if #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
);
  logic              hold;
  logic              flush;
  logic              id_valid;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [RIDX_W-1:0] id_rs1;
  logic [RIDX_W-1:0] id_rs2;
  logic [RIDX_W-1:0] id_rd;
  logic [1:0]        id_aluop;
  logic [2:0]        id_funct3;
  logic              id_funct7b5;
  logic              id_alusrc;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;
  logic              id_branch;
  logic              exm_regwrite;
  logic [RIDX_W-1:0] exm_rd;
  logic [XLEN-1:0]   exm_alu_out;
  logic              mwb_regwrite;
  logic [RIDX_W-1:0] mwb_rd;
  logic [XLEN-1:0]   mwb_wdata;

  logic [XLEN-1:0]   alu_rs1;
  logic [XLEN-1:0]   alu_rs2;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   ex_store_data;
  logic              ex_valid;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_branch;
  logic [RIDX_W-1:0] ex_rd;
  logic [XLEN-1:0]   ex_imm;
  logic              load_use_stall;

  modport master (
    output hold, flush, id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_aluop, id_funct3, id_funct7b5, id_alusrc, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, id_branch, exm_regwrite, exm_rd, exm_alu_out,
           mwb_regwrite, mwb_rd, mwb_wdata,
    input  alu_rs1, alu_rs2, alu_ctrl, ex_store_data, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_memtoreg, ex_branch, ex_rd, ex_imm, load_use_stall
  );

  modport slave (
    input  hold, flush, id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_aluop, id_funct3, id_funct7b5, id_alusrc, id_regwrite, id_memread,
           id_memwrite, id_memtoreg, id_branch, exm_regwrite, exm_rd, exm_alu_out,
           mwb_regwrite, mwb_rd, mwb_wdata,
    output alu_rs1, alu_rs2, alu_ctrl, ex_store_data, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_memtoreg, ex_branch, ex_rd, ex_imm, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage_fwd_select.sv
// Forwarding select for one source operand: EX/MEM beats MEM/WB, x0 never forwards.
module fwd_select
  import id_ex_stage_pkg::*;
#(
  parameter int RIDX_W = 5
) (
  input  logic [RIDX_W-1:0] src,
  input  logic              exm_regwrite,
  input  logic [RIDX_W-1:0] exm_rd,
  input  logic              mwb_regwrite,
  input  logic [RIDX_W-1:0] mwb_rd,
  output fwd_sel_e          sel
);
  always_comb begin
    // NOTE: default assigned first so every path drives sel; a missing branch would infer a latch.
    sel = FWD_RF;
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == src)) begin
      sel = FWD_EXM;
    end else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == src)) begin
      sel = FWD_MWB;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: registers decoded operands/control, decodes ALU control,
// forwards from EX/MEM and MEM/WB, and inserts bubbles on load-use hazards.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  ex_ctrl_t          ctrl_q;
  logic [RIDX_W-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
  fwd_sel_e          sel_rs1, sel_rs2;
  logic              stall;

  // An external hold outranks the hazard: the load stays in EX, so no bubble is needed.
  assign stall = !bus.hold && ctrl_q.memread && ctrl_q.valid && (rd_q != '0) && bus.id_valid &&
                 ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset || bus.flush || stall) begin
      ctrl_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (!bus.hold) begin
      ctrl_q     <= '{valid:    bus.id_valid,
                      regwrite: bus.id_regwrite,
                      memread:  bus.id_memread,
                      memwrite: bus.id_memwrite,
                      memtoreg: bus.id_memtoreg,
                      branch:   bus.id_branch,
                      alusrc:   bus.id_alusrc,
                      aluop:    aluop_e'(bus.id_aluop),
                      funct3:   bus.id_funct3,
                      funct7b5: bus.id_funct7b5};
      rs1_q      <= bus.id_rs1;
      rs2_q      <= bus.id_rs2;
      rd_q       <= bus.id_rd;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
    end
  end

  fwd_select #(.RIDX_W(RIDX_W)) u_fwd_rs1 (
    .src(rs1_q), .exm_regwrite(bus.exm_regwrite), .exm_rd(bus.exm_rd),
    .mwb_regwrite(bus.mwb_regwrite), .mwb_rd(bus.mwb_rd), .sel(sel_rs1)
  );

  fwd_select #(.RIDX_W(RIDX_W)) u_fwd_rs2 (
    .src(rs2_q), .exm_regwrite(bus.exm_regwrite), .exm_rd(bus.exm_rd),
    .mwb_regwrite(bus.mwb_regwrite), .mwb_rd(bus.mwb_rd), .sel(sel_rs2)
  );

  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
    case (sel_rs1)
      FWD_EXM: fwd_rs1 = bus.exm_alu_out;
      FWD_MWB: fwd_rs1 = bus.mwb_wdata;
      default: fwd_rs1 = rs1_data_q;
    endcase
    case (sel_rs2)
      FWD_EXM: fwd_rs2 = bus.exm_alu_out;
      FWD_MWB: fwd_rs2 = bus.mwb_wdata;
      default: fwd_rs2 = rs2_data_q;
    endcase
  end

  assign bus.alu_rs1        = fwd_rs1;
  assign bus.alu_rs2        = ctrl_q.alusrc ? imm_q : fwd_rs2;
  assign bus.ex_store_data  = fwd_rs2;
  assign bus.alu_ctrl       = alu_decode(ctrl_q.aluop, ctrl_q.funct3, ctrl_q.funct7b5);
  assign bus.ex_valid       = ctrl_q.valid;
  assign bus.ex_regwrite    = ctrl_q.regwrite;
  assign bus.ex_memread     = ctrl_q.memread;
  assign bus.ex_memwrite    = ctrl_q.memwrite;
  assign bus.ex_memtoreg    = ctrl_q.memtoreg;
  assign bus.ex_branch      = ctrl_q.branch;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_imm         = imm_q;
  assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hand-written sequences for
// reset, load-use stalls, flush/hold priority; expected outputs flow through a queue.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;

  id_ex_stage_if #(.XLEN(64), .RIDX_W(5)) bus ();

  id_ex_stage #(.XLEN(64), .RIDX_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // flags order: {valid, regwrite, memread, memwrite, memtoreg, branch}
  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] store;
    logic [63:0] imm;
    logic [3:0]  ctrl;
    logic [5:0]  flags;
    logic [4:0]  rd;
  } out_t;

  typedef struct {
    logic [5:0]  flags;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [63:0] exm_out;
    logic        mwb_we;
    logic [4:0]  mwb_rd;
    logic [63:0] mwb_data;
    out_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  out_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {bus.id_valid, bus.id_regwrite, bus.id_memread,
     bus.id_memwrite, bus.id_memtoreg, bus.id_branch} = v.flags;
    bus.id_alusrc    = v.alusrc;
    bus.id_aluop     = v.aluop;
    bus.id_funct3    = v.f3;
    bus.id_funct7b5  = v.f7;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rd        = v.rd;
    bus.id_rs1_data  = v.d1;
    bus.id_rs2_data  = v.d2;
    bus.id_imm       = v.imm;
    bus.exm_regwrite = v.exm_we;
    bus.exm_rd       = v.exm_rd;
    bus.exm_alu_out  = v.exm_out;
    bus.mwb_regwrite = v.mwb_we;
    bus.mwb_rd       = v.mwb_rd;
    bus.mwb_wdata    = v.mwb_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    out_t e;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".alu_rs1"}, bus.alu_rs1, e.rs1);
      check({tag, ".alu_rs2"}, bus.alu_rs2, e.rs2);
      check({tag, ".ex_store_data"}, bus.ex_store_data, e.store);
      check({tag, ".ex_imm"}, bus.ex_imm, e.imm);
      check({tag, ".alu_ctrl"}, 64'(bus.alu_ctrl), 64'(e.ctrl));
      check({tag, ".ex_flags"}, 64'({bus.ex_valid, bus.ex_regwrite, bus.ex_memread,
                                     bus.ex_memwrite, bus.ex_memtoreg, bus.ex_branch}),
            64'(e.flags));
      check({tag, ".ex_rd"}, 64'(bus.ex_rd), 64'(e.rd));
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    sb.push_back(v.exp);
    tick();
    compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t base, v, vl, vh;
    out_t zero;

    zero = '{rs1: 64'h0, rs2: 64'h0, store: 64'h0, imm: 64'h0, ctrl: 4'b0010,
             flags: 6'b0, rd: 5'd0};

    base.flags = 6'b110000; base.alusrc = 1'b0; base.aluop = 2'b10; base.f3 = 3'b000;
    base.f7 = 1'b0; base.rs1 = 5'd1; base.rs2 = 5'd2; base.rd = 5'd3;
    base.d1 = 64'h11; base.d2 = 64'h22; base.imm = 64'h99;
    base.exm_we = 1'b0; base.exm_rd = 5'd0; base.exm_out = 64'hE0;
    base.mwb_we = 1'b0; base.mwb_rd = 5'd0; base.mwb_data = 64'hF0;
    base.exp = '{rs1: 64'h11, rs2: 64'h22, store: 64'h22, imm: 64'h99, ctrl: 4'b0010,
                 flags: 6'b110000, rd: 5'd3};

    // ---- vector table ----
    vecs.push_back(base);                                        // R add
    v = base; v.f7 = 1'b1; v.exp.ctrl = 4'b0110; vecs.push_back(v);        // R sub
    v = base; v.f3 = 3'b111; v.exp.ctrl = 4'b0000; vecs.push_back(v);      // and
    v = base; v.f3 = 3'b110; v.exp.ctrl = 4'b0001; vecs.push_back(v);      // or
    v = base; v.aluop = 2'b01; v.f3 = 3'b111; v.flags = 6'b100001;
    v.exp.ctrl = 4'b0110; v.exp.flags = 6'b100001; vecs.push_back(v);      // branch sub
    v = base; v.aluop = 2'b11; v.f3 = 3'b111; v.f7 = 1'b1; vecs.push_back(v); // reserved aluop
    v = base; v.f3 = 3'b100; v.f7 = 1'b1; vecs.push_back(v);               // other funct3
    v = base; v.aluop = 2'b00; v.f3 = 3'b111; v.f7 = 1'b1; vecs.push_back(v); // add ignores funct
    v = base; v.rs1 = 5'd5; v.d1 = 64'h55; v.exm_we = 1'b1; v.exm_rd = 5'd5; v.exm_out = 64'hAA;
    v.mwb_we = 1'b1; v.mwb_rd = 5'd5; v.mwb_data = 64'hBB; v.exp.rs1 = 64'hAA; vecs.push_back(v);
    v.exm_we = 1'b0; v.exp.rs1 = 64'hBB; vecs.push_back(v);                // MEM/WB only
    v.exm_we = 1'b1; v.exm_rd = 5'd0; v.mwb_rd = 5'd0; v.exp.rs1 = 64'h55; vecs.push_back(v);
    v = base; v.rs2 = 5'd9; v.imm = 64'h10; v.alusrc = 1'b1; v.flags = 6'b100100;
    v.mwb_we = 1'b1; v.mwb_rd = 5'd9; v.mwb_data = 64'h33;
    v.exp.rs2 = 64'h10; v.exp.store = 64'h33; v.exp.imm = 64'h10; v.exp.flags = 6'b100100;
    vecs.push_back(v);                                           // ALUSrc store
    v = base; v.rs1 = 5'd12; v.rs2 = 5'd12; v.d1 = 64'h1; v.d2 = 64'h2;
    v.exm_we = 1'b1; v.exm_rd = 5'd12; v.exm_out = 64'hCC; v.mwb_we = 1'b1; v.mwb_rd = 5'd12;
    v.mwb_data = 64'hDD; v.exp.rs1 = 64'hCC; v.exp.rs2 = 64'hCC; v.exp.store = 64'hCC;
    vecs.push_back(v);                                           // EX/MEM wins on both
    v = base; v.rs1 = 5'd0; v.rs2 = 5'd0; v.d1 = 64'h123; v.d2 = 64'h456;
    v.exm_we = 1'b1; v.exm_rd = 5'd0; v.exm_out = 64'hAA; v.mwb_we = 1'b1; v.mwb_rd = 5'd0;
    v.exp.rs1 = 64'h123; v.exp.rs2 = 64'h456; v.exp.store = 64'h456; vecs.push_back(v); // x0
    v = base; v.rs1 = 5'd3; v.rs2 = 5'd20; v.rd = 5'd8; v.flags = 6'b111010;
    v.exm_we = 1'b1; v.exm_rd = 5'd3; v.exm_out = 64'h3333; v.mwb_we = 1'b1; v.mwb_rd = 5'd20;
    v.mwb_data = 64'h2020; v.exp.rs1 = 64'h3333; v.exp.rs2 = 64'h2020; v.exp.store = 64'h2020;
    v.exp.flags = 6'b111010; v.exp.rd = 5'd8; vecs.push_back(v); // mixed sources, load
    v = base; v.flags = 6'b010000; v.exp.flags = 6'b010000; vecs.push_back(v); // invalid slot
    v = base; v.rs2 = 5'd4; v.mwb_we = 1'b0; v.mwb_rd = 5'd4; vecs.push_back(v); // no regwrite

    // ---- reset from power-up ----
    bus.hold = 1'b0; bus.flush = 1'b0;
    drive(base);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    sb.push_back(zero);
    compare("por");
    check("por.load_use_stall", 64'(bus.load_use_stall), 64'd0);

    // ---- table ----
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // ---- reset mid-stream with a valid instruction presented ----
    apply(base, "pre_rst");
    reset = 1'b1;
    sb.push_back(zero); tick(); compare("rst1");
    sb.push_back(zero); tick(); compare("rst2");
    reset = 1'b0;

    // ---- load-use hazard ----
    vl = base; vl.rd = 5'd7; vl.flags = 6'b111010; vl.exp.rd = 5'd7; vl.exp.flags = 6'b111010;
    apply(vl, "lu_load");
    v = base; v.rs2 = 5'd7;
    drive(v); #1;
    check("lu.stall_high", 64'(bus.load_use_stall), 64'd1);
    sb.push_back(zero); tick(); compare("lu_bubble");
    check("lu.stall_cleared", 64'(bus.load_use_stall), 64'd0);
    sb.push_back(v.exp); tick(); compare("lu_reissue");

    // load to x0: no hazard
    vh = vl; vh.rd = 5'd0; vh.exp.rd = 5'd0;
    apply(vh, "lu0_load");
    v = base; v.rs1 = 5'd0; v.rs2 = 5'd0; v.exp.rs1 = 64'h11; v.exp.rs2 = 64'h22;
    drive(v); #1;
    check("lu0.stall_low", 64'(bus.load_use_stall), 64'd0);
    sb.push_back(v.exp); tick(); compare("lu0_next");

    // hold masks the stall and freezes the load in EX
    apply(vl, "luh_load");
    v = base; v.rs1 = 5'd7;
    drive(v); bus.hold = 1'b1; #1;
    check("luh.stall_masked", 64'(bus.load_use_stall), 64'd0);
    sb.push_back(vl.exp); tick(); compare("luh_frozen");
    bus.hold = 1'b0; #1;
    check("luh.stall_after_hold", 64'(bus.load_use_stall), 64'd1);
    sb.push_back(zero); tick(); compare("luh_bubble");

    // ---- flush beats hold ----
    apply(base, "pri_load");
    bus.flush = 1'b1; bus.hold = 1'b1;
    sb.push_back(zero); tick(); compare("flush_hold");
    bus.flush = 1'b0; bus.hold = 1'b0;

    // ---- hold for 3 cycles; forwarding tracks live EX/MEM ----
    vh = base; vh.rs1 = 5'd5; vh.d1 = 64'h55; vh.rd = 5'd9; vh.f3 = 3'b111;
    vh.exp.rs1 = 64'h55; vh.exp.rd = 5'd9; vh.exp.ctrl = 4'b0000;
    apply(vh, "hold_load");
    v = base; v.rd = 5'd30; v.f3 = 3'b110; v.exm_we = 1'b1; v.exm_rd = 5'd5;
    drive(v);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_t e;
      bus.exm_alu_out = 64'h100 + 64'(i);
      e = vh.exp;
      e.rs1 = 64'h100 + 64'(i);
      sb.push_back(e);
      tick();
      compare($sformatf("hold%0d", i));
    end
    bus.hold = 1'b0;

    // ---- flush alone ----
    bus.flush = 1'b1;
    sb.push_back(zero); tick(); compare("flush");
    bus.flush = 1'b0;

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
